decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the 5-stage RV32I pipeline, between the IF/ID handoff and EX.
//  - Classifies the opcode into a 3-bit itype and instantiates immdec to get simm/uimm.
//  - Extracts register fields.
//  - Registers all results into the ID/EX pipeline register.
//  - Valid/ready handshake both sides; supports hazard stall and branch flush.
// PARAMETERS
//  XLEN   32   datapath/PC width (only 32 supported)
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     async active-low reset
//  if_valid     in   1     IF presents instruction
//  if_instr     in   32    instruction word
//  if_pc        in   XLEN  PC of if_instr
//  id_ready     out  1     stage accepts if_instr this cycle
//  stall        in   1     hazard unit: hold, accept nothing
//  flush        in   1     EX redirect: kill ID/EX contents and input
//  ex_ready     in   1     EX consumes ex_* this cycle
//  ex_valid     out  1     ex_* hold a valid decoded instruction
//  ex_pc        out  XLEN  registered PC
//  ex_opcode    out  7     instr[6:0]
//  ex_rd        out  5     instr[11:7]
//  ex_funct3    out  3     instr[14:12]
//  ex_rs1       out  5     instr[19:15]
//  ex_rs2       out  5     instr[24:20]
//  ex_funct7b5  out  1     instr[30]
//  ex_itype     out  3     instruction format
//  ex_simm      out  32    sign-extended immediate
//  ex_uimm      out  32    zero-extended immediate
//  ex_illegal   out  1     unrecognised opcode
// BEHAVIOUR
//  - itype encoding: R=000, I=001, B=010, S=011, U=100, J=101.
//  - Opcode map:
//    - 0110011 -> R
//    - 0000011/0010011/1100111/1110011 -> I
//    - 0100011 -> S
//    - 1100011 -> B
//    - 0110111/0010111 -> U
//    - 1101111 -> J
//    - anything else -> itype=R, illegal=1
//  - ex_simm/ex_uimm are forced to 0 for R and for illegal instructions; X must never be registered.
//  - id_ready = !stall && !flush && (!ex_valid || ex_ready). Purely combinational; no dependence on if_valid.
//  - Load: if_valid && id_ready. All ex_* data regs update; ex_valid<=1. Latency is 1 cycle.
//  - ex_valid && ex_ready with no load: ex_valid<=0; data regs hold.
//  - No handshake on either side: all regs hold, so ex_* remain stable while ex_valid && !ex_ready.
//  - stall=1, not flush: no load.
//    - ex_valid clears if ex_ready (consumed); otherwise holds.
//  - flush=1: ex_valid<=0 next edge regardless of ex_ready/stall; input not accepted.
//    - flush has priority over stall and load.
//  - rst_n low (async, any time incl. mid-transfer): every ex_* output <=0.
//    - ex_valid=0 so id_ready=!stall&&!flush.
//  - Data regs need no reset functionally; they are reset to 0 anyway for clean waveforms.
// STRUCTURE
//  - Shared package riscv_pkg:
//    - itype constants ITYPE_R/I/B/S/U/J
//    - opcode constants OP_*
//  - Sub-module: immdec, existing and unchanged. Fed itype from the classifier and the raw if_instr.
//  - Classifier: a combinational function in this file.
//  - One always block for the ID/EX register.
// TESTING
//  1. addi x1,x0,-1 (0xFFF00093), ex_ready=1
//     -> next cycle ex_valid=1, itype=001, rd=1, simm=0xFFFFFFFF, uimm=0x00000FFF.
//  2. Back-to-back:
//     - sw x1,12(x2) (0x00112623) -> simm=0x0000000C, itype=011, rs1=2, rs2=1.
//     - then jal x0,-4 (0xFFDFF06F) -> simm=0xFFFFFFFC, uimm=0x001FFFFC, itype=101.
//     - One per cycle, no bubbles.
//  3. lui x5,0x12345 (0x123452B7) with ex_ready=0 for 3 cycles
//     -> simm=uimm=0x12345000 stable; id_ready=0.
//     -> Second instr accepted only the cycle ex_ready rises.
//  4. flush asserted in the same cycle as if_valid with ex_valid=1
//     -> id_ready=0, ex_valid=0 next cycle, instr dropped.
//  5. 0x00000000 -> ex_illegal=1, itype=000, simm=uimm=0.
//     R-type add (0x002081B3) -> illegal=0, simm=uimm=0.
//  6. rst_n pulsed low mid-stall
//     -> all outputs 0 immediately (async).
//     -> After release, first valid instr decoded in 1 cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: itype/opcode constants,
// classifier result and ID/EX bundle types.
package riscv_pkg;

    localparam logic [2:0] ITYPE_R = 3'b000;
    localparam logic [2:0] ITYPE_I = 3'b001;
    localparam logic [2:0] ITYPE_B = 3'b010;
    localparam logic [2:0] ITYPE_S = 3'b011;
    localparam logic [2:0] ITYPE_U = 3'b100;
    localparam logic [2:0] ITYPE_J = 3'b101;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [2:0] itype;
        logic       illegal;
    } cls_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        funct7b5;
        logic [2:0]  itype;
        logic [31:0] simm;
        logic [31:0] uimm;
        logic        illegal;
    } id_ex_t;

endpackage

// File: rtl/immdec.sv
// Immediate decoder: builds sign- and zero-extended immediates
// from the raw instruction; itype selects the format (R -> 0).
// Ports: itype_i, instr_i in; simm_o, uimm_o out.
module immdec
    import riscv_pkg::*;
(
    input  logic [2:0]  itype_i,
    input  logic [31:0] instr_i,
    output logic [31:0] simm_o,
    output logic [31:0] uimm_o
);

    logic [31:0] i;
    logic        unused_op;

    assign i         = instr_i;
    assign unused_op = ^instr_i[6:0];

    always_comb begin
        simm_o = '0;
        uimm_o = '0;
        unique case (itype_i)
            ITYPE_I: begin
                simm_o = {{20{i[31]}}, i[31:20]};
                uimm_o = {20'b0, i[31:20]};
            end
            ITYPE_S: begin
                simm_o = {{20{i[31]}}, i[31:25], i[11:7]};
                uimm_o = {20'b0, i[31:25], i[11:7]};
            end
            ITYPE_B: begin
                simm_o = {{19{i[31]}}, i[31], i[7],
                          i[30:25], i[11:8], 1'b0};
                uimm_o = {19'b0, i[31], i[7],
                          i[30:25], i[11:8], 1'b0};
            end
            ITYPE_U: begin
                simm_o = {i[31:12], 12'b0};
                uimm_o = {i[31:12], 12'b0};
            end
            ITYPE_J: begin
                simm_o = {{11{i[31]}}, i[31], i[19:12],
                          i[20], i[30:21], 1'b0};
                uimm_o = {11'b0, i[31], i[19:12],
                          i[20], i[30:21], 1'b0};
            end
            default: begin
                simm_o = '0;
                uimm_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: classifies opcode, decodes immediates and fields,
// and registers them into ID/EX with valid/ready, stall and flush.
// Ports: clk, rst_n; IF side if_valid/if_instr/if_pc/id_ready;
// hazard stall/flush; EX side ex_ready/ex_valid and ex_* fields.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            stall,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [6:0]      ex_opcode,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic            ex_funct7b5,
    output logic [2:0]      ex_itype,
    output logic [31:0]     ex_simm,
    output logic [31:0]     ex_uimm,
    output logic            ex_illegal
);

    function automatic cls_t classify(input logic [6:0] op);
        cls_t c;
        c.itype   = ITYPE_R;
        c.illegal = 1'b0;
        unique case (op)
            OP_OP:     c.itype = ITYPE_R;
            OP_LOAD,
            OP_OPIMM,
            OP_JALR,
            OP_SYSTEM: c.itype = ITYPE_I;
            OP_STORE:  c.itype = ITYPE_S;
            OP_BRANCH: c.itype = ITYPE_B;
            OP_LUI,
            OP_AUIPC:  c.itype = ITYPE_U;
            OP_JAL:    c.itype = ITYPE_J;
            default: begin
                c.itype   = ITYPE_R;
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

    cls_t        cls;
    logic [31:0] simm;
    logic [31:0] uimm;
    logic        load;
    logic        valid_q, valid_d;
    id_ex_t      ex_q, ex_d;

    assign cls = classify(if_instr[6:0]);

    // Illegal opcodes are classified as R, so immdec yields zero.
    immdec u_immdec (
        .itype_i (cls.itype),
        .instr_i (if_instr),
        .simm_o  (simm),
        .uimm_o  (uimm)
    );

    assign id_ready = !stall && !flush && (!valid_q || ex_ready);
    assign load     = if_valid && id_ready;

    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d       = 1'b1;
            ex_d.pc       = 32'(if_pc);
            ex_d.opcode   = if_instr[6:0];
            ex_d.rd       = if_instr[11:7];
            ex_d.funct3   = if_instr[14:12];
            ex_d.rs1      = if_instr[19:15];
            ex_d.rs2      = if_instr[24:20];
            ex_d.funct7b5 = if_instr[30];
            ex_d.itype    = cls.itype;
            ex_d.simm     = simm;
            ex_d.uimm     = uimm;
            ex_d.illegal  = cls.illegal;
        end else if (valid_q && ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ex_q    <= ex_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = XLEN'(ex_q.pc);
    assign ex_opcode   = ex_q.opcode;
    assign ex_rd       = ex_q.rd;
    assign ex_funct3   = ex_q.funct3;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_funct7b5 = ex_q.funct7b5;
    assign ex_itype    = ex_q.itype;
    assign ex_simm     = ex_q.simm;
    assign ex_uimm     = ex_q.uimm;
    assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-result queue.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        stall;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_funct7b5;
    logic [2:0]  ex_itype;
    logic [31:0] ex_simm;
    logic [31:0] ex_uimm;
    logic        ex_illegal;

    decode_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .stall       (stall),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_opcode   (ex_opcode),
        .ex_rd       (ex_rd),
        .ex_funct3   (ex_funct3),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_funct7b5 (ex_funct7b5),
        .ex_itype    (ex_itype),
        .ex_simm     (ex_simm),
        .ex_uimm     (ex_uimm),
        .ex_illegal  (ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  itype;
        logic [31:0] simm;
        logic [31:0] uimm;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    logic mv;
    int   chk_cnt;
    int   pass_cnt;
    int   fail_cnt;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr,
                                input logic [31:0] pc,
                                input logic [2:0]  it,
                                input logic [31:0] s,
                                input logic [31:0] u,
                                input logic        il);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.itype = it;
        e.simm  = s;
        e.uimm  = u;
        e.ill   = il;
        return e;
    endfunction

    task automatic chk_out(input exp_t e);
        logic [31:0] w;
        w = e.instr;
        chk("pc", ex_pc, e.pc);
        chk("opcode", 32'(ex_opcode), 32'(w[6:0]));
        chk("rd", 32'(ex_rd), 32'(w[11:7]));
        chk("funct3", 32'(ex_funct3), 32'(w[14:12]));
        chk("rs1", 32'(ex_rs1), 32'(w[19:15]));
        chk("rs2", 32'(ex_rs2), 32'(w[24:20]));
        chk("f7b5", 32'(ex_funct7b5), 32'(w[30]));
        chk("itype", 32'(ex_itype), 32'(e.itype));
        chk("simm", ex_simm, e.simm);
        chk("uimm", ex_uimm, e.uimm);
        chk("illegal", 32'(ex_illegal), 32'(e.ill));
    endtask

    task automatic chk_zero();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_opcode", 32'(ex_opcode), 32'd0);
        chk("rst_rd", 32'(ex_rd), 32'd0);
        chk("rst_funct3", 32'(ex_funct3), 32'd0);
        chk("rst_rs1", 32'(ex_rs1), 32'd0);
        chk("rst_rs2", 32'(ex_rs2), 32'd0);
        chk("rst_f7b5", 32'(ex_funct7b5), 32'd0);
        chk("rst_itype", 32'(ex_itype), 32'd0);
        chk("rst_simm", ex_simm, 32'd0);
        chk("rst_uimm", ex_uimm, 32'd0);
        chk("rst_illegal", 32'(ex_illegal), 32'd0);
    endtask

    // One clock: drive at negedge, check ready, update model, check outputs.
    task automatic step(input logic v, input logic st,
                        input logic fl, input logic er,
                        input exp_t e);
        logic rdy;
        logic ld;
        if_valid = v;
        if_instr = e.instr;
        if_pc    = e.pc;
        stall    = st;
        flush    = fl;
        ex_ready = er;
        #1;
        rdy = !st && !fl && (!mv || er);
        chk("id_ready", 32'(id_ready), 32'(rdy));
        ld = v && rdy;
        @(posedge clk);
        if (fl) begin
            mv = 1'b0;
            sb.delete();
        end else if (ld) begin
            if (sb.size() > 0) void'(sb.pop_front());
            sb.push_back(e);
            mv = 1'b1;
        end else if (mv && er) begin
            mv = 1'b0;
            void'(sb.pop_front());
        end
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(mv));
        if (mv) chk_out(sb[0]);
        @(negedge clk);
    endtask

    exp_t addi, sw, jal, lui, add, ill, nop;

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        fail_cnt = 0;
        mv       = 1'b0;
        addi = mk(32'hFFF00093, 32'h100, 3'b001,
                  32'hFFFFFFFF, 32'h00000FFF, 1'b0);
        sw   = mk(32'h00112623, 32'h104, 3'b011,
                  32'h0000000C, 32'h0000000C, 1'b0);
        jal  = mk(32'hFFDFF06F, 32'h108, 3'b101,
                  32'hFFFFFFFC, 32'h001FFFFC, 1'b0);
        lui  = mk(32'h123452B7, 32'h10C, 3'b100,
                  32'h12345000, 32'h12345000, 1'b0);
        add  = mk(32'h002081B3, 32'h110, 3'b000,
                  32'h0, 32'h0, 1'b0);
        ill  = mk(32'h00000000, 32'h114, 3'b000,
                  32'h0, 32'h0, 1'b1);
        nop  = mk(32'h00000013, 32'h0, 3'b001,
                  32'h0, 32'h0, 1'b0);

        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        #2;
        chk_zero();
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // addi, then sw/jal back-to-back, then drain
        step(1, 0, 0, 1, addi);
        step(1, 0, 0, 1, sw);
        step(1, 0, 0, 1, jal);
        step(0, 0, 0, 1, nop);

        // lui held by EX back-pressure for 3 cycles
        step(1, 0, 0, 0, lui);
        step(1, 0, 0, 0, add);
        step(1, 0, 0, 0, add);
        step(1, 0, 0, 0, add);
        step(1, 0, 0, 1, add);

        // flush with valid input while ex_valid=1
        step(1, 0, 1, 0, sw);
        step(0, 0, 0, 1, nop);

        // illegal then R-type
        step(1, 0, 0, 1, ill);
        step(1, 0, 0, 1, add);

        // stall with EX consuming clears valid
        step(1, 0, 0, 1, addi);
        step(1, 1, 0, 1, add);

        // flush beats stall
        step(1, 0, 0, 0, jal);
        step(1, 1, 1, 0, add);

        // reset pulsed mid-stall
        step(1, 0, 0, 0, lui);
        step(1, 1, 0, 0, add);
        if_valid = 1'b1;
        if_instr = add.instr;
        stall    = 1'b1;
        ex_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero();
        chk("rst_stall_rdy", 32'(id_ready), 32'd0);
        stall = 1'b0;
        #1;
        chk("rst_rdy", 32'(id_ready), 32'd1);
        mv = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 1, addi);
        step(0, 0, 0, 1, nop);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
